// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared state encoding and access-legality check for the RV32 memory port
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP_I = 2'd1,
    ST_RESP_D = 2'd2
  } state_e;

  // Legal when word aligned (if required) and inside a 2**aw-word RAM (if range checking).
  function automatic logic access_ok(input logic [31:0] addr, input logic need_align,
                                     input int unsigned aw, input logic range_check);
    logic [31:0] hi;
    hi = addr >> (aw + 32'd2);
    access_ok = !(need_align && (addr[1:0] != 2'b00)) && !(range_check && (hi != 32'd0));
  endfunction

endpackage

// File: rtl/rv32_mem_addr_check.sv
// rtl/rv32_mem_addr_check.sv - combinational legality check for one requester's byte address
module rv32_mem_addr_check
  import rv32_mem_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter bit          RANGE_CHECK = 1'b1
) (
  input  logic [31:0] addr_i,
  input  logic        align_i,
  output logic        ok_o
);

  assign ok_o = access_ok(addr_i, align_i, AW, RANGE_CHECK);

endmodule

// File: rtl/rv32_mem_arbiter.sv
// rtl/rv32_mem_arbiter.sv - shares one single-port word RAM between fetch and load/store channels
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter bit          RANGE_CHECK = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_ack,
  output logic [31:0]      i_rdata,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  input  logic [3:0]       d_mask,
  output logic             d_ack,
  output logic [31:0]      d_rdata,
  output logic             err,
  output logic             ram_en,
  output logic [3:0]       ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  output logic [CNT_W-1:0] i_wait_cnt
);

  state_e           state_q;
  logic             i_ack_q, d_ack_q, err_q, d_upd_q;
  logic [31:0]      i_rdata_q, d_rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             i_ok, d_ok, d_req, i_elig, d_elig, grant_i, grant_d, i_bad, d_bad;

  rv32_mem_addr_check #(.AW(AW), .RANGE_CHECK(RANGE_CHECK)) u_chk_i (
    .addr_i(i_addr), .align_i(1'b1), .ok_o(i_ok)
  );

  // Stores may be byte-misaligned; only loads need word alignment.
  rv32_mem_addr_check #(.AW(AW), .RANGE_CHECK(RANGE_CHECK)) u_chk_d (
    .addr_i(d_addr), .align_i(d_read), .ok_o(d_ok)
  );

  // The requester being acked this cycle still holds its req, so it sits out arbitration.
  assign d_req   = d_read | d_write;
  assign i_elig  = i_req && (state_q != ST_RESP_I);
  assign d_elig  = d_req && (state_q != ST_RESP_D);
  assign grant_d = d_elig;
  assign grant_i = i_elig && !d_elig;
  assign d_bad   = (d_read && d_write) || !d_ok;
  assign i_bad   = !i_ok;

  assign ram_en    = !rst && ((grant_d && !d_bad) || (grant_i && !i_bad));
  assign ram_we    = (!rst && grant_d && !d_bad && d_write) ? d_mask : 4'b0000;
  assign ram_addr  = grant_d ? d_addr[AW+1:2] : i_addr[AW+1:2];
  assign ram_wdata = d_wdata;

  // RAM data arrives in the ack cycle, so read data is forwarded there and held afterwards.
  assign i_ack      = i_ack_q && !rst;
  assign d_ack      = d_ack_q && !rst;
  assign err        = err_q && !rst;
  assign i_rdata    = i_ack ? (err ? 32'd0 : ram_rdata) : i_rdata_q;
  assign d_rdata    = (d_ack && d_upd_q) ? (err ? 32'd0 : ram_rdata) : d_rdata_q;
  assign i_wait_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      d_upd_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      cnt_q     <= '0;
    end else begin
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
      i_ack_q   <= grant_i;
      d_ack_q   <= grant_d;
      err_q     <= (grant_d && d_bad) || (grant_i && i_bad);
      d_upd_q   <= grant_d && (d_read || d_bad);
      if (grant_d)      state_q <= ST_RESP_D;
      else if (grant_i) state_q <= ST_RESP_I;
      else              state_q <= ST_IDLE;
      if (i_req && !grant_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb/tb_rv32_mem_arbiter.sv - directed self-checking bench for rv32_mem_arbiter
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [31:0] i_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
  logic [3:0]  d_mask = 4'd0;
  logic        i_ack, d_ack, err, ram_en;
  logic [31:0] i_rdata, d_rdata, ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [3:0]  i_wait_cnt;
  logic [31:0] mem [0:255];

  int vectors = 0;
  int miscompares = 0;

  rv32_mem_arbiter #(.AW(8), .RANGE_CHECK(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mask(d_mask), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .i_wait_cnt(i_wait_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
    end
  end

  task automatic test_reset;
    d_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL rst_ram_en got=%0b exp=0", ram_en); end
    vectors++; if (ram_we !== 4'b0000) begin miscompares++; $display("FAIL rst_ram_we got=%b exp=0000", ram_we); end
    vectors++; if ({i_ack, d_ack, err} !== 3'b000) begin miscompares++; $display("FAIL rst_acks got=%b exp=000", {i_ack, d_ack, err}); end
    vectors++; if (i_rdata !== 32'd0 || d_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_rdata got=%h/%h exp=0/0", i_rdata, d_rdata); end
    vectors++; if (i_wait_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_cnt got=%0d exp=0", i_wait_cnt); end
    d_read = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fetch_only;
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    vectors++; if (ram_en !== 1'b1 || ram_addr !== 8'd4) begin miscompares++; $display("FAIL fetch_grant got en=%0b addr=%0d exp en=1 addr=4", ram_en, ram_addr); end
    vectors++; if (ram_we !== 4'b0000) begin miscompares++; $display("FAIL fetch_we got=%b exp=0000", ram_we); end
    @(negedge clk);
    vectors++; if (i_ack !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL fetch_ack got ack=%0b err=%0b exp ack=1 err=0", i_ack, err); end
    vectors++; if (i_rdata !== 32'h00500093) begin miscompares++; $display("FAIL fetch_rdata got=%h exp=00500093", i_rdata); end
    i_req = 1'b0;
    @(negedge clk);
    vectors++; if (i_ack !== 1'b0 || i_rdata !== 32'h00500093) begin miscompares++; $display("FAIL fetch_hold got ack=%0b rdata=%h exp ack=0 rdata=00500093", i_ack, i_rdata); end
  endtask

  task automatic test_contention;
    i_req = 1'b1; i_addr = 32'h10; d_read = 1'b1; d_addr = 32'h20;
    #1;
    vectors++; if (ram_en !== 1'b1 || ram_addr !== 8'd8) begin miscompares++; $display("FAIL cont_data_first got en=%0b addr=%0d exp en=1 addr=8", ram_en, ram_addr); end
    @(negedge clk);
    vectors++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin miscompares++; $display("FAIL cont_d_ack got d=%0b i=%0b exp d=1 i=0", d_ack, i_ack); end
    vectors++; if (d_rdata !== 32'h12345678) begin miscompares++; $display("FAIL cont_d_rdata got=%h exp=12345678", d_rdata); end
    vectors++; if (ram_en !== 1'b1 || ram_addr !== 8'd4) begin miscompares++; $display("FAIL cont_fetch_grant got en=%0b addr=%0d exp en=1 addr=4", ram_en, ram_addr); end
    d_read = 1'b0;
    @(negedge clk);
    vectors++; if (i_ack !== 1'b1 || d_ack !== 1'b0) begin miscompares++; $display("FAIL cont_i_ack got i=%0b d=%0b exp i=1 d=0", i_ack, d_ack); end
    vectors++; if (i_rdata !== 32'h00500093) begin miscompares++; $display("FAIL cont_i_rdata got=%h exp=00500093", i_rdata); end
    vectors++; if (i_wait_cnt !== 4'd1) begin miscompares++; $display("FAIL cont_wait_cnt got=%0d exp=1", i_wait_cnt); end
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_store;
    d_write = 1'b1; d_addr = 32'h41; d_mask = 4'b0010; d_wdata = 32'h0000AB00;
    #1;
    vectors++; if (ram_en !== 1'b1 || ram_we !== 4'b0010 || ram_addr !== 8'd16) begin miscompares++; $display("FAIL store_port got en=%0b we=%b addr=%0d exp en=1 we=0010 addr=16", ram_en, ram_we, ram_addr); end
    @(negedge clk);
    vectors++; if (d_ack !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL store_ack got ack=%0b err=%0b exp ack=1 err=0", d_ack, err); end
    vectors++; if (d_rdata !== 32'h12345678) begin miscompares++; $display("FAIL store_rdata_kept got=%h exp=12345678", d_rdata); end
    d_write = 1'b0; d_mask = 4'b0000; d_read = 1'b1; d_addr = 32'h40;
    @(negedge clk);
    for (int k = 0; k < 4 && d_ack !== 1'b1; k++) @(negedge clk);
    vectors++; if (d_ack !== 1'b1) begin miscompares++; $display("FAIL reload_ack got=%0b exp=1", d_ack); end
    vectors++; if (d_rdata !== 32'h1122AB44) begin miscompares++; $display("FAIL reload_rdata got=%h exp=1122ab44", d_rdata); end
    d_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_errors;
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h40;
    #1;
    vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL rw_both_en got=%0b exp=0", ram_en); end
    @(negedge clk);
    vectors++; if (d_ack !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL rw_both_ack got ack=%0b err=%0b exp 1/1", d_ack, err); end
    vectors++; if (d_rdata !== 32'd0) begin miscompares++; $display("FAIL rw_both_rdata got=%h exp=0", d_rdata); end
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    vectors++; if (err !== 1'b0 || d_ack !== 1'b0) begin miscompares++; $display("FAIL err_pulse got err=%0b ack=%0b exp 0/0", err, d_ack); end
    i_req = 1'b1; i_addr = 32'h402;
    #1;
    vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL bad_fetch_en got=%0b exp=0", ram_en); end
    @(negedge clk);
    vectors++; if (i_ack !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL bad_fetch_ack got ack=%0b err=%0b exp 1/1", i_ack, err); end
    vectors++; if (i_rdata !== 32'd0) begin miscompares++; $display("FAIL bad_fetch_rdata got=%h exp=0", i_rdata); end
    i_req = 1'b0; d_read = 1'b1; d_addr = 32'h42;
    #1;
    vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL misalign_load_en got=%0b exp=0", ram_en); end
    @(negedge clk);
    vectors++; if (d_ack !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL misalign_load_ack got ack=%0b err=%0b exp 1/1", d_ack, err); end
    d_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h0; d_read = 1'b1; d_addr = 32'h0;
    repeat (10) @(negedge clk);
    vectors++; if (i_wait_cnt !== 4'd5) begin miscompares++; $display("FAIL sat_mid got=%0d exp=5", i_wait_cnt); end
    repeat (30) @(negedge clk);
    vectors++; if (i_wait_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_final got=%0d exp=15", i_wait_cnt); end
    vectors++; if (d_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL sat_d_rdata got=%h exp=cafef00d", d_rdata); end
    i_req = 1'b0; d_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_resp_d;
    d_read = 1'b1; d_addr = 32'h20;
    @(posedge clk);
    #1;
    rst = 1'b1; d_read = 1'b0;
    #1;
    vectors++; if (d_ack !== 1'b0 || err !== 1'b0 || ram_en !== 1'b0) begin miscompares++; $display("FAIL rstd_no_ack got ack=%0b err=%0b en=%0b exp 0/0/0", d_ack, err, ram_en); end
    @(negedge clk);
    @(negedge clk);
    vectors++; if (i_rdata !== 32'd0 || d_rdata !== 32'd0 || i_wait_cnt !== 4'd0) begin miscompares++; $display("FAIL rstd_values got i=%h d=%h cnt=%0d exp 0/0/0", i_rdata, d_rdata, i_wait_cnt); end
    vectors++; if (d_ack !== 1'b0) begin miscompares++; $display("FAIL rstd_ack_low got=%0b exp=0", d_ack); end
    rst = 1'b0; d_read = 1'b1; d_addr = 32'h20;
    #1;
    vectors++; if (ram_en !== 1'b1 || ram_addr !== 8'd8) begin miscompares++; $display("FAIL rstd_fresh_grant got en=%0b addr=%0d exp en=1 addr=8", ram_en, ram_addr); end
    @(negedge clk);
    vectors++; if (d_ack !== 1'b1 || d_rdata !== 32'h12345678 || err !== 1'b0) begin miscompares++; $display("FAIL rstd_fresh_ack got ack=%0b rdata=%h err=%0b exp 1/12345678/0", d_ack, d_rdata, err); end
    d_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[0]  = 32'hCAFEF00D;
    mem[4]  = 32'h00500093;
    mem[8]  = 32'h12345678;
    mem[16] = 32'h11223344;
    test_reset();
    test_fetch_only();
    test_contention();
    test_byte_store();
    test_errors();
    test_saturation();
    test_reset_resp_d();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
